// File: rtl/mac_feed_align_pkg.sv
// Shared constants and width helpers for the MAC feed front end.
package mac_feed_pkg;

  localparam int unsigned MODE_LAST  = 0;
  localparam int unsigned MODE_COUNT = 1;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned ch_w(input int unsigned a);
    return $clog2(a) + 1;
  endfunction

endpackage

// File: rtl/mac_feed_align_if.sv
// Stream-in / row-out bundle between the sources, the feed aligner and the MAC.
interface mac_feed_align_if #(
  parameter int unsigned A    = 2,
  parameter int unsigned DW_F = 64,
  parameter int unsigned DW_V = 32
);
  logic [DW_F-1:0]   f_data;
  logic              f_valid;
  logic              f_last;
  logic              f_ready;
  logic [DW_V-1:0]   v_data;
  logic              v_valid;
  logic              v_ready;
  logic [A*DW_F-1:0] m_row;
  logic [DW_V-1:0]   v_out;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic              ovf_err;
  logic [31:0]       beat_cnt;

  modport slave (
    input  f_data, f_valid, f_last, v_data, v_valid, out_ready,
    output f_ready, v_ready, m_row, v_out, out_valid, out_last, ovf_err, beat_cnt
  );

  modport master (
    output f_data, f_valid, f_last, v_data, v_valid, out_ready,
    input  f_ready, v_ready, m_row, v_out, out_valid, out_last, ovf_err, beat_cnt
  );
endinterface

// File: rtl/mac_feed_align_fifo.sv
// Synchronous FIFO with registered read data; flush empties it like reset.
module mac_feed_fifo
  import mac_feed_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (cnt_q == CNT_W'(DEPTH));
    empty    = (cnt_q == '0);
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    dout_d   = do_pop ? mem_q[rd_ptr_q] : dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      dout_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; the empty count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout = dout_q;
endmodule

// File: rtl/mac_feed_align.sv
// Round-robin F demux into per-channel FIFOs, vinput buffer, lock-step pop into a registered row beat.
module mac_feed_align
  import mac_feed_pkg::*;
#(
  parameter int unsigned A       = 2,
  parameter int unsigned DW_F    = 64,
  parameter int unsigned DW_V    = 32,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned MODE    = MODE_LAST,
  parameter int unsigned ROW_LEN = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  mac_feed_align_if.slave bus
);
  localparam int unsigned CH_W = ch_w(A);
  localparam int unsigned RB_W = $clog2(ROW_LEN) + 1;

  logic [DW_F:0]   ch_dout [A];
  logic [A-1:0]    ch_full, ch_empty, ch_push, ch_last;
  logic [DW_V-1:0] v_dout;
  logic            v_full, v_empty;

  logic            rdy_en_q, rdy_en_d;
  logic [CH_W-1:0] ch_cnt_q, ch_cnt_d;
  logic [RB_W-1:0] row_beat_q, row_beat_d;
  logic            out_valid_q, out_valid_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     beat_cnt_q, beat_cnt_d;
  logic            f_ready, v_ready, f_acc, v_acc, pop, adv, sel_full;
  logic            unused_last;

  always_comb begin
    sel_full = 1'b0;
    for (int unsigned a = 0; a < A; a++)
      if (ch_cnt_q == CH_W'(a)) sel_full = ch_full[a];
    f_ready = rdy_en_q & ~sel_full;
    v_ready = rdy_en_q & ~v_full;
    f_acc   = bus.f_valid & f_ready;
    v_acc   = bus.v_valid & v_ready;
    for (int unsigned a = 0; a < A; a++)
      ch_push[a] = f_acc & (ch_cnt_q == CH_W'(a));
    pop = (&(~ch_empty)) & ~v_empty & (~out_valid_q | bus.out_ready);

    if (MODE == MODE_COUNT) adv = f_acc & (row_beat_q == RB_W'(ROW_LEN - 1));
    else                    adv = f_acc & bus.f_last;

    row_beat_d = row_beat_q;
    if (MODE == MODE_COUNT && f_acc)
      row_beat_d = adv ? '0 : row_beat_q + RB_W'(1);
    ch_cnt_d = ch_cnt_q;
    if (adv) ch_cnt_d = (ch_cnt_q == CH_W'(A - 1)) ? '0 : ch_cnt_q + CH_W'(1);

    out_valid_d = pop ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
    beat_cnt_d  = beat_cnt_q + 32'(out_valid_q & bus.out_ready);
    ovf_d       = ovf_q | (bus.f_valid & ~f_ready) | (bus.v_valid & ~v_ready);
    rdy_en_d    = 1'b1;
    if (flush) begin
      ch_cnt_d    = '0;
      row_beat_d  = '0;
      out_valid_d = 1'b0;
      beat_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q    <= 1'b0;
      ch_cnt_q    <= '0;
      row_beat_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      rdy_en_q    <= rdy_en_d;
      ch_cnt_q    <= ch_cnt_d;
      row_beat_q  <= row_beat_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // The FIFOs' registered read data doubles as the output stage: it only moves on pop.
  for (genvar a = 0; a < A; a++) begin : g_ch
    mac_feed_fifo #(.DW(DW_F + 1), .DEPTH(DEPTH)) u_ch_fifo (
      .clk(clk), .rst(rst), .flush(flush),
      .push(ch_push[a]), .pop(pop),
      .din({bus.f_last, bus.f_data}),
      .dout(ch_dout[a]),
      .full(ch_full[a]), .empty(ch_empty[a])
    );
    assign bus.m_row[a*DW_F +: DW_F] = ch_dout[a][DW_F-1:0];
    assign ch_last[a] = ch_dout[a][DW_F];
  end

  mac_feed_fifo #(.DW(DW_V), .DEPTH(DEPTH)) u_v_fifo (
    .clk(clk), .rst(rst), .flush(flush),
    .push(v_acc), .pop(pop),
    .din(bus.v_data),
    .dout(v_dout),
    .full(v_full), .empty(v_empty)
  );

  assign unused_last   = ^ch_last;
  assign bus.f_ready   = f_ready;
  assign bus.v_ready   = v_ready;
  assign bus.v_out     = v_dout;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = ch_last[0];
  assign bus.ovf_err   = ovf_q;
  assign bus.beat_cnt  = beat_cnt_q;
endmodule

// File: tb/tb_mac_feed_align.sv
// Directed bench for mac_feed_align: three configurations exercised in one linear sequence.
module tb_mac_feed_align;
  logic clk = 1'b0;
  logic rst0, rst1, rst2, flush0, flush1, flush2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mac_feed_align_if #(.A(2), .DW_F(16), .DW_V(8)) if0 ();
  mac_feed_align_if #(.A(4), .DW_F(16), .DW_V(8)) if1 ();
  mac_feed_align_if #(.A(2), .DW_F(16), .DW_V(8)) if2 ();

  mac_feed_align #(.A(2), .DW_F(16), .DW_V(8), .DEPTH(16), .MODE(0), .ROW_LEN(14))
    dut0 (.clk(clk), .rst(rst0), .flush(flush0), .bus(if0.slave));
  mac_feed_align #(.A(4), .DW_F(16), .DW_V(8), .DEPTH(4), .MODE(1), .ROW_LEN(3))
    dut1 (.clk(clk), .rst(rst1), .flush(flush1), .bus(if1.slave));
  mac_feed_align #(.A(2), .DW_F(16), .DW_V(8), .DEPTH(4), .MODE(0), .ROW_LEN(14))
    dut2 (.clk(clk), .rst(rst2), .flush(flush2), .bus(if2.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    flush0 = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    if0.f_data = '0; if0.f_valid = 1'b0; if0.f_last = 1'b0; if0.v_data = '0; if0.v_valid = 1'b0; if0.out_ready = 1'b0;
    if1.f_data = '0; if1.f_valid = 1'b0; if1.f_last = 1'b0; if1.v_data = '0; if1.v_valid = 1'b0; if1.out_ready = 1'b0;
    if2.f_data = '0; if2.f_valid = 1'b0; if2.f_last = 1'b0; if2.v_data = '0; if2.v_valid = 1'b0; if2.out_ready = 1'b0;
    tick; tick;

    // reset state
    check("rst_out_valid", 64'(if0.out_valid), 64'(1'b0));
    check("rst_m_row",     64'(if0.m_row),     64'(0));
    check("rst_beat_cnt",  64'(if0.beat_cnt),  64'(0));
    check("rst_f_ready",   64'(if0.f_ready),   64'(1'b0));
    check("rst_ovf",       64'(if0.ovf_err),   64'(1'b0));
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    check("rel_f_ready_0", 64'(if0.f_ready), 64'(1'b0));
    tick;
    check("rel_f_ready_1", 64'(if0.f_ready), 64'(1'b1));
    check("rel_v_ready_1", 64'(if0.v_ready), 64'(1'b1));

    // test 1 + 3: A=2 MODE=0, stall of 10 cycles after five beats
    for (int k = 0; k < 28; k++) begin
      if0.f_valid = 1'b1;
      if0.f_data  = (k < 14) ? 16'(16'h100 + k) : 16'(16'h200 + k - 14);
      if0.f_last  = (k == 13 || k == 27);
      tick;
    end
    if0.f_valid = 1'b0; if0.f_last = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if0.v_valid = 1'b1; if0.v_data = 8'(8'h40 + k);
      tick;
    end
    if0.v_valid = 1'b0;
    check("t1_held_valid", 64'(if0.out_valid), 64'(1'b1));
    check("t1_cnt_before", 64'(if0.beat_cnt), 64'(0));
    if0.out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k == 5) begin
        if0.out_ready = 1'b0;
        for (int s = 0; s < 10; s++) begin
          tick;
          check("t3_stall_row", 64'(if0.m_row), 64'({16'h205, 16'h105}));
          check("t3_stall_v",   64'(if0.v_out), 64'(8'h45));
          check("t3_stall_cnt", 64'(if0.beat_cnt), 64'(5));
        end
        if0.out_ready = 1'b1;
      end
      check("t1_valid", 64'(if0.out_valid), 64'(1'b1));
      check("t1_row",   64'(if0.m_row), 64'({16'(16'h200 + k), 16'(16'h100 + k)}));
      check("t1_v",     64'(if0.v_out), 64'(8'(8'h40 + k)));
      check("t1_last",  64'(if0.out_last), 64'(k == 13));
      tick;
    end
    check("t1_drained", 64'(if0.out_valid), 64'(1'b0));
    check("t1_cnt",     64'(if0.beat_cnt), 64'(14));

    // test 2: A=4 MODE=1 ROW_LEN=3
    for (int j = 0; j < 12; j++) begin
      if1.f_valid = 1'b1; if1.f_data = 16'(16'h10 + j); if1.f_last = 1'b0;
      check("t2_f_ready", 64'(if1.f_ready), 64'(1'b1));
      tick;
    end
    if1.f_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if1.v_valid = 1'b1; if1.v_data = 8'(8'h80 + k);
      tick;
    end
    if1.v_valid = 1'b0;
    if1.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t2_valid", 64'(if1.out_valid), 64'(1'b1));
      check("t2_row", 64'(if1.m_row),
            {16'(16'h19 + k), 16'(16'h16 + k), 16'(16'h13 + k), 16'(16'h10 + k)});
      check("t2_v",    64'(if1.v_out), 64'(8'(8'h80 + k)));
      check("t2_last", 64'(if1.out_last), 64'(1'b0));
      tick;
    end
    check("t2_drained", 64'(if1.out_valid), 64'(1'b0));
    check("t2_cnt",     64'(if1.beat_cnt), 64'(3));

    // test 4: DEPTH=4 overflow on ch0, flag survives flush
    for (int i = 0; i < 5; i++) begin
      if2.f_valid = 1'b1; if2.f_data = 16'(16'h500 + i); if2.f_last = 1'b0;
      check("t4_f_ready", 64'(if2.f_ready), 64'(i < 4));
      if (i == 4) check("t4_ovf_pre", 64'(if2.ovf_err), 64'(1'b0));
      tick;
    end
    if2.f_valid = 1'b0;
    check("t4_ovf_set", 64'(if2.ovf_err), 64'(1'b1));
    check("t4_no_out",  64'(if2.out_valid), 64'(1'b0));
    flush2 = 1'b1;
    tick;
    flush2 = 1'b0;
    check("t4_ovf_kept",   64'(if2.ovf_err), 64'(1'b1));
    check("t4_ready_back", 64'(if2.f_ready), 64'(1'b1));

    // test 5: reset mid-burst on dut0
    if0.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if0.f_valid = 1'b1;
      if0.f_data  = (k < 3) ? 16'(16'hA00 + k) : 16'(16'hB00 + k - 3);
      if0.f_last  = (k == 2 || k == 5);
      tick;
    end
    if0.f_valid = 1'b0; if0.f_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if0.v_valid = 1'b1; if0.v_data = 8'(8'hC0 + k);
      tick;
    end
    if0.v_valid = 1'b0;
    check("t5_pre_valid", 64'(if0.out_valid), 64'(1'b1));
    rst0 = 1'b1;
    tick;
    check("t5_rst_valid", 64'(if0.out_valid), 64'(1'b0));
    check("t5_rst_cnt",   64'(if0.beat_cnt), 64'(0));
    check("t5_rst_row",   64'(if0.m_row), 64'(0));
    check("t5_rst_v",     64'(if0.v_out), 64'(0));
    rst0 = 1'b0;
    tick;
    if0.f_valid = 1'b1; if0.f_data = 16'hD00; if0.f_last = 1'b1;
    if0.v_valid = 1'b1; if0.v_data = 8'hF0;
    tick;
    if0.v_valid = 1'b0; if0.f_data = 16'hE00;
    tick;
    if0.f_valid = 1'b0; if0.f_last = 1'b0; if0.out_ready = 1'b1;
    tick;
    check("t5_fresh_valid", 64'(if0.out_valid), 64'(1'b1));
    check("t5_fresh_row",   64'(if0.m_row), 64'({16'hE00, 16'hD00}));
    check("t5_fresh_v",     64'(if0.v_out), 64'(8'hF0));
    check("t5_fresh_last",  64'(if0.out_last), 64'(1'b1));
    tick;
    check("t5_no_stale", 64'(if0.out_valid), 64'(1'b0));
    check("t5_cnt",      64'(if0.beat_cnt), 64'(1));

    // test 6: flush coincident with push and pop
    if0.out_ready = 1'b0;
    if0.f_valid = 1'b1; if0.f_data = 16'h111; if0.f_last = 1'b1;
    if0.v_valid = 1'b1; if0.v_data = 8'h33;
    tick;
    if0.v_valid = 1'b0; if0.f_data = 16'h222;
    tick;
    flush0 = 1'b1;
    if0.f_data = 16'h999; if0.v_valid = 1'b1; if0.v_data = 8'h44;
    tick;
    flush0 = 1'b0; if0.f_valid = 1'b0; if0.f_last = 1'b0; if0.v_valid = 1'b0;
    check("t6_valid",   64'(if0.out_valid), 64'(1'b0));
    check("t6_row",     64'(if0.m_row), 64'(0));
    check("t6_cnt",     64'(if0.beat_cnt), 64'(0));
    check("t6_f_ready", 64'(if0.f_ready), 64'(1'b1));
    check("t6_ovf",     64'(if0.ovf_err), 64'(1'b0));
    if0.f_valid = 1'b1; if0.f_data = 16'h777; if0.f_last = 1'b1;
    if0.v_valid = 1'b1; if0.v_data = 8'h55;
    tick;
    if0.v_valid = 1'b0; if0.f_data = 16'h888;
    tick;
    if0.f_valid = 1'b0; if0.f_last = 1'b0; if0.out_ready = 1'b1;
    tick;
    check("t6_next_valid", 64'(if0.out_valid), 64'(1'b1));
    check("t6_next_row",   64'(if0.m_row), 64'({16'h888, 16'h777}));
    check("t6_next_v",     64'(if0.v_out), 64'(8'h55));
    tick;
    check("t6_empty_after", 64'(if0.out_valid), 64'(1'b0));
    check("t6_cnt_after",   64'(if0.beat_cnt), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
